// File: rtl/alien_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alien_pkg
// Brief   : Shared defaults, edge-code bit positions and FSM encoding for the
//           alien-matrix edge detector.
// Revision: 1.0 - initial release
// ============================================================================
package alien_pkg;

   localparam int DEF_ALIEN_ROW    = 4;
   localparam int DEF_ALIEN_COLUMN = 8;

   // Bit positions inside HitEdgeCode
   localparam int EDGE_LEFT   = 3;
   localparam int EDGE_TOP    = 2;
   localparam int EDGE_RIGHT  = 1;
   localparam int EDGE_BOTTOM = 0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LATCH    = 3'd1,
      S_SCAN_COL = 3'd2,
      S_SCAN_ROW = 3'd3,
      S_COMPARE  = 3'd4,
      S_REPORT   = 3'd5
   } state_t;

endpackage : alien_pkg
`default_nettype wire

// File: rtl/alien_mask_scanner.sv
`default_nettype none
// ============================================================================
// Module  : alien_mask_scanner
// Brief   : Holds the per-frame snapshot of position and alive mask, walks the
//           columns then the rows one per cycle, and tracks the live bounding
//           box (first/last live column, last live row).
// Revision: 1.0 - initial release
// ============================================================================
module alien_mask_scanner #(
   parameter int ALIEN_ROW    = 4,
   parameter int ALIEN_COLUMN = 8,
   parameter int COL_W        = (ALIEN_COLUMN > 1) ? $clog2(ALIEN_COLUMN) : 1,
   parameter int ROW_W        = (ALIEN_ROW > 1) ? $clog2(ALIEN_ROW) : 1
) (
   input  logic                              clk,
   input  logic                              resetN,
   input  logic                              load,
   input  logic                              scanCol,
   input  logic                              scanRow,
   input  logic signed [10:0]                topLeftX,
   input  logic signed [10:0]                topLeftY,
   input  logic [ALIEN_ROW*ALIEN_COLUMN-1:0] aliveMask,
   output logic signed [10:0]                snapX,
   output logic signed [10:0]                snapY,
   output logic [COL_W-1:0]                  minCol,
   output logic [COL_W-1:0]                  maxCol,
   output logic [ROW_W-1:0]                  maxRow,
   output logic                              colLast,
   output logic                              scanDone
);

   localparam int NW = (COL_W > ROW_W) ? COL_W : ROW_W;

   logic [ALIEN_ROW*ALIEN_COLUMN-1:0]       r_mask;
   logic [NW-1:0]                           r_cnt;
   logic                                    r_found;
   logic [ALIEN_COLUMN-1:0][ALIEN_ROW-1:0]  w_colBits;
   logic [ALIEN_COLUMN-1:0]                 w_colLiveVec;
   logic [ALIEN_ROW-1:0]                    w_rowLiveVec;

   // Transpose the snapshot so each column's row bits can be OR-reduced
   for (genvar c = 0; c < ALIEN_COLUMN; c++) begin : g_col
      for (genvar r = 0; r < ALIEN_ROW; r++) begin : g_row_bit
         assign w_colBits[c][r] = r_mask[r*ALIEN_COLUMN + c];
      end
      assign w_colLiveVec[c] = |w_colBits[c];
   end

   for (genvar r = 0; r < ALIEN_ROW; r++) begin : g_row
      assign w_rowLiveVec[r] = |r_mask[r*ALIEN_COLUMN +: ALIEN_COLUMN];
   end

   assign colLast  = scanCol && (r_cnt == NW'(ALIEN_COLUMN - 1));
   assign scanDone = scanRow && (r_cnt == NW'(ALIEN_ROW - 1));

   // Snapshot on load, then one column (or row) per cycle updating the trackers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_mask  <= '0;
         snapX   <= '0;
         snapY   <= '0;
         r_cnt   <= '0;
         r_found <= 1'b0;
         minCol  <= '0;
         maxCol  <= '0;
         maxRow  <= '0;
      end else if (load) begin
         r_mask  <= aliveMask;
         snapX   <= topLeftX;
         snapY   <= topLeftY;
         r_cnt   <= '0;
         r_found <= 1'b0;
         minCol  <= '0;
         maxCol  <= '0;
         maxRow  <= '0;
      end else if (scanCol) begin
         if (w_colLiveVec[r_cnt[COL_W-1:0]]) begin
            if (!r_found) begin
               minCol  <= r_cnt[COL_W-1:0];
               r_found <= 1'b1;
            end
            maxCol <= r_cnt[COL_W-1:0];
         end
         // Counter is reused for the row pass, so wrap after the last column
         r_cnt <= colLast ? '0 : r_cnt + NW'(1);
      end else if (scanRow) begin
         if (w_rowLiveVec[r_cnt[ROW_W-1:0]]) begin
            maxRow <= r_cnt[ROW_W-1:0];
         end
         r_cnt <= r_cnt + NW'(1);
      end
   end

endmodule : alien_mask_scanner
`default_nettype wire

// File: rtl/alien_matrix_edge_detector.sv
`default_nettype none
// ============================================================================
// Module  : alien_matrix_edge_detector
// Brief   : Once per frame finds the live bounding box of the alien matrix,
//           compares it to the playfield borders and issues at most one
//           collision report; also flags a defeated matrix and a ground hit.
// Revision: 1.0 - initial release
// ============================================================================
module alien_matrix_edge_detector import alien_pkg::*; #(
   parameter int ALIEN_ROW     = DEF_ALIEN_ROW,
   parameter int ALIEN_COLUMN  = DEF_ALIEN_COLUMN,
   parameter int ALIEN_W       = 32,
   parameter int ALIEN_H       = 32,
   parameter int LEFT_BORDER   = 0,
   parameter int RIGHT_BORDER  = 639,
   parameter int BOTTOM_BORDER = 400
) (
   input  logic                              clk,
   input  logic                              resetN,
   input  logic                              startOfFrame,
   input  logic                              playGame,
   input  logic signed [10:0]                topLeftX,
   input  logic signed [10:0]                topLeftY,
   input  logic [ALIEN_ROW*ALIEN_COLUMN-1:0] aliveMask,
   output logic                              collision,
   output logic [3:0]                        HitEdgeCode,
   output logic                              matrixDefeated,
   output logic                              alienReachedBottom
);

   localparam int COL_W = (ALIEN_COLUMN > 1) ? $clog2(ALIEN_COLUMN) : 1;
   localparam int ROW_W = (ALIEN_ROW > 1) ? $clog2(ALIEN_ROW) : 1;

   localparam logic signed [11:0] c_leftBorder   = 12'(LEFT_BORDER);
   localparam logic signed [11:0] c_rightBorder  = 12'(RIGHT_BORDER);
   localparam logic signed [11:0] c_bottomBorder = 12'(BOTTOM_BORDER);

   state_t                r_state;
   logic                  r_defeatArmed;
   logic                  r_left;
   logic                  r_right;
   logic                  r_bottom;

   logic signed [10:0]    w_snapX;
   logic signed [10:0]    w_snapY;
   logic [COL_W-1:0]      w_minCol;
   logic [COL_W-1:0]      w_maxCol;
   logic [ROW_W-1:0]      w_maxRow;
   logic                  w_colLast;
   logic                  w_scanDone;

   logic signed [11:0]    w_xExt;
   logic signed [11:0]    w_yExt;
   logic signed [11:0]    w_offL;
   logic signed [11:0]    w_offR;
   logic signed [11:0]    w_offB;
   logic signed [11:0]    w_leftX;
   logic signed [11:0]    w_rightX;
   logic signed [11:0]    w_bottomY;
   logic [3:0]            w_code;

   alien_mask_scanner #(
      .ALIEN_ROW    (ALIEN_ROW),
      .ALIEN_COLUMN (ALIEN_COLUMN),
      .COL_W        (COL_W),
      .ROW_W        (ROW_W)
   ) u_scanner (
      .clk       (clk),
      .resetN    (resetN),
      .load      (r_state == S_LATCH),
      .scanCol   (r_state == S_SCAN_COL),
      .scanRow   (r_state == S_SCAN_ROW),
      .topLeftX  (topLeftX),
      .topLeftY  (topLeftY),
      .aliveMask (aliveMask),
      .snapX     (w_snapX),
      .snapY     (w_snapY),
      .minCol    (w_minCol),
      .maxCol    (w_maxCol),
      .maxRow    (w_maxRow),
      .colLast   (w_colLast),
      .scanDone  (w_scanDone)
   );

   // Bounding-box edges in 12-bit signed pixels; one extra bit avoids overflow
   always_comb begin
      w_xExt    = {w_snapX[10], w_snapX};
      w_yExt    = {w_snapY[10], w_snapY};
      w_offL    = 12'(int'(w_minCol) * ALIEN_W);
      w_offR    = 12'((int'(w_maxCol) + 1) * ALIEN_W);
      w_offB    = 12'((int'(w_maxRow) + 1) * ALIEN_H);
      w_leftX   = w_xExt + w_offL;
      w_rightX  = w_xExt + w_offR - 12'sd1;
      w_bottomY = w_yExt + w_offB - 12'sd1;
   end

   // Assemble the edge code from the registered flags; top is never reported
   always_comb begin
      w_code              = '0;
      w_code[EDGE_LEFT]   = r_left;
      w_code[EDGE_TOP]    = 1'b0;
      w_code[EDGE_RIGHT]  = r_right;
      w_code[EDGE_BOTTOM] = r_bottom;
   end

   // Frame sequencer with registered pulse and flag outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state            <= S_IDLE;
         r_defeatArmed      <= 1'b1;
         r_left             <= 1'b0;
         r_right            <= 1'b0;
         r_bottom           <= 1'b0;
         collision          <= 1'b0;
         HitEdgeCode        <= '0;
         matrixDefeated     <= 1'b0;
         alienReachedBottom <= 1'b0;
      end else begin
         collision      <= 1'b0;
         HitEdgeCode    <= '0;
         matrixDefeated <= 1'b0;
         if (!playGame) begin
            r_state            <= S_IDLE;
            r_defeatArmed      <= 1'b1;
            alienReachedBottom <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (startOfFrame) r_state <= S_LATCH;
               end
               S_LATCH: begin
                  // Empty mask: report defeat once, then stay quiet until refilled
                  if (aliveMask == '0) begin
                     if (r_defeatArmed) begin
                        matrixDefeated <= 1'b1;
                        r_defeatArmed  <= 1'b0;
                     end
                     r_state <= S_IDLE;
                  end else begin
                     r_defeatArmed <= 1'b1;
                     r_state       <= S_SCAN_COL;
                  end
               end
               S_SCAN_COL: begin
                  if (w_colLast) r_state <= S_SCAN_ROW;
               end
               S_SCAN_ROW: begin
                  if (w_scanDone) r_state <= S_COMPARE;
               end
               S_COMPARE: begin
                  r_left   <= (w_leftX <= c_leftBorder);
                  r_right  <= (w_rightX >= c_rightBorder);
                  r_bottom <= (w_bottomY >= c_bottomBorder);
                  r_state  <= S_REPORT;
               end
               S_REPORT: begin
                  if (r_left || r_right || r_bottom) begin
                     collision   <= 1'b1;
                     HitEdgeCode <= w_code;
                  end
                  if (r_bottom) alienReachedBottom <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule : alien_matrix_edge_detector
`default_nettype wire
